rf_wr_arbiter: RTL
==================

Name: rf_wr_arbiter

Overview:
Arbitrates the register file's single write port (RFWr/A3/WD) among three writers.
- Pipeline writeback stage: fixed top priority, never back-pressured.
- Multi-cycle unit (mul/div): valid/ready handshake.
- Board debug write port: valid/ready handshake.

The two lower requesters share idle slots round-robin. A starvation counter raises a stall request to the pipeline so writeback cannot lock them out indefinitely.

Parameters:
STARVE_LIMIT, 8, consecutive wait cycles of a pending lower requester before stall_req asserts (legal 2..255)
CNT_W, 8, width of the wait counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
wb_we  in  1  writeback stage write enable
wb_rd  in  5  writeback destination register
wb_wd  in  32  writeback data
mc_valid  in  1  multi-cycle unit write request
mc_rd  in  5  multi-cycle destination register
mc_wd  in  32  multi-cycle data
mc_ready  out  1  multi-cycle request accepted this cycle
dbg_valid  in  1  debug write request
dbg_rd  in  5  debug destination register
dbg_wd  in  32  debug data
dbg_ready  out  1  debug request accepted this cycle
stall_req  out  1  asks the pipeline to hold a bubble in writeback
rf_we  out  1  to RF RFWr
rf_a3  out  5  to RF A3
rf_wd  out  32  to RF WD

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous, active low; every register clears immediately on assertion.
- Reset values: stall_req=0, wait_cnt=0, rr_last=DBG (so MC wins the first tie). Combinational outputs mc_ready, dbg_ready, rf_we are 0 whenever rst_n=0.
- WB slot busy: wb_busy = wb_we && wb_rd!=0. A WB write to x0 does not occupy the slot.
- Grant, combinational, same cycle:
  - if wb_busy: WB granted.
  - else if exactly one of mc_valid/dbg_valid: that requester granted.
  - else if both valid: the one NOT equal to rr_last granted.
  - else: nothing granted.
- Ready and handshake:
  - mc_ready = MC granted; dbg_ready = DBG granted.
  - A handshake completes at the rising edge where valid&&ready. The RF commits the write on that same edge.
  - The requester must hold rd/wd stable while valid && !ready.
- RF outputs, combinational from the grant mux:
  - rf_we=1 only when the granted rd!=0.
  - rf_a3/rf_wd = granted rd/wd; all zero when nothing is granted.
- x0 writes: a lower-requester write to x0 is still granted (ready=1) and consumes its round-robin turn, but rf_we=0.
- rr_last update: on each MC or DBG grant, rr_last <= granted requester. Unchanged otherwise.
- Wait counter:
  - pending = (mc_valid||dbg_valid) && neither granted.
  - If pending: wait_cnt <= wait_cnt+1, saturating at STARVE_LIMIT.
  - Else: wait_cnt <= 0.
- stall_req:
  - Set to 1 at the edge where pending and wait_cnt == STARVE_LIMIT-1.
  - Cleared, together with wait_cnt, at the edge after any MC or DBG grant.
  - Also cleared if both lower valids drop while no lower requester is granted.
- Pipeline contract: the pipeline inserts a writeback bubble (wb_we=0) the cycle after it sees stall_req. If wb_busy persists anyway, WB still wins and stall_req stays 1. No WB write is ever lost.
- Simultaneous events:
  - WB, MC and DBG all valid: WB granted; rr_last unchanged; counter increments.
  - A valid that drops without a handshake leaves no state behind except the counter rule above.
- Reset mid-handshake: no write occurs. The requester re-presents its request after reset.

Test Plan:
- Reset, then wb_we=1, wb_rd=5, wb_wd=0x11 with mc_valid=1 → rf_we=1, rf_a3=5, rf_wd=0x11, mc_ready=0.
- WB idle; mc_valid=dbg_valid=1 held for 4 cycles, each requester dropping valid after its handshake then re-asserting → grants alternate MC, DBG, MC, DBG starting with MC after reset.
- wb_we=1, wb_rd=0, dbg_valid=1, dbg_rd=3, dbg_wd=0xAB → DBG granted, rf_a3=3, rf_wd=0xAB, rf_we=1.
- mc_valid=1, mc_rd=0 → mc_ready=1, rf_we=0; on the next cycle with both lower requesters valid, DBG is granted.
- WB busy every cycle, mc_valid=1, STARVE_LIMIT=8 → stall_req rises at the 8th edge. The bench drops wb_we → mc_ready=1 that cycle; stall_req=0 and wait_cnt=0 after the next edge.
- Assert rst_n=0 mid-wait with wait_cnt=5 and stall_req=1 → stall_req=0 and ready outputs 0 immediately. After release, a tie grants MC first.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has fixed top priority, the
// multi-cycle unit and debug port share idle slots round-robin with starvation relief.
module rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_wd,
    output logic        mc_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_wd,
    output logic        dbg_ready,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd
);
    typedef enum logic {SRC_MC = 1'b0, SRC_DBG = 1'b1} src_e;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    src_e             rr_last;
    logic [CNT_W-1:0] wait_cnt;
    logic             wb_busy;
    logic             gnt_wb;
    logic             gnt_mc;
    logic             gnt_dbg;
    logic             pending;

    // A writeback to x0 is a no-op, so it does not take the slot away.
    assign wb_busy = wb_we && (wb_rd != 5'd0);

    // Grants are forced low while in reset so no write can leak out.
    always_comb begin
        gnt_wb  = 1'b0;
        gnt_mc  = 1'b0;
        gnt_dbg = 1'b0;
        if (rst_n) begin
            if (wb_busy) begin
                gnt_wb = 1'b1;
            end else if (mc_valid && dbg_valid) begin
                if (rr_last == SRC_DBG) gnt_mc  = 1'b1;
                else                    gnt_dbg = 1'b1;
            end else if (mc_valid) begin
                gnt_mc = 1'b1;
            end else if (dbg_valid) begin
                gnt_dbg = 1'b1;
            end
        end
    end

    always_comb begin
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        if (gnt_wb) begin
            rf_a3 = wb_rd;
            rf_wd = wb_wd;
        end else if (gnt_mc) begin
            rf_a3 = mc_rd;
            rf_wd = mc_wd;
        end else if (gnt_dbg) begin
            rf_a3 = dbg_rd;
            rf_wd = dbg_wd;
        end
    end

    assign rf_we     = (gnt_wb || gnt_mc || gnt_dbg) && (rf_a3 != 5'd0);
    assign mc_ready  = gnt_mc;
    assign dbg_ready = gnt_dbg;
    assign pending   = (mc_valid || dbg_valid) && !gnt_mc && !gnt_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last   <= SRC_DBG;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            if (gnt_mc)       rr_last <= SRC_MC;
            else if (gnt_dbg) rr_last <= SRC_DBG;

            // Once set, stall_req holds until a lower requester is served or gives up.
            if (pending) begin
                if (wait_cnt != LIMIT)    wait_cnt  <= wait_cnt + 1'b1;
                if (wait_cnt == LIMIT_M1) stall_req <= 1'b1;
            end else begin
                wait_cnt  <= '0;
                stall_req <= 1'b0;
            end
        end
    end
endmodule
